// File: rtl/ped_signal_if.sv
// ped_signal_if: lamp, button and pedestrian-output bundle between the controller side and ped_signal
// Ports: car_red/car_green/car_yellow/btn driven by the controller side (master);
//        ped_req/walk/stop/remain[6:0]/fault driven by ped_signal (slave).
interface ped_signal_if;
    logic       car_red;
    logic       car_green;
    logic       car_yellow;
    logic       btn;
    logic       ped_req;
    logic       walk;
    logic       stop;
    logic [6:0] remain;
    logic       fault;
    modport master (
        output car_red, car_green, car_yellow, btn,
        input  ped_req, walk, stop, remain, fault
    );
    modport slave (
        input  car_red, car_green, car_yellow, btn,
        output ped_req, walk, stop, remain, fault
    );
endinterface

// File: rtl/ped_signal.sv
// ped_signal: pedestrian WALK/STOP lamps, walk countdown, debounced button and request pulse
// Ports: clk; rst_n (async active-low);
//        bus.slave: car_red/car_green/car_yellow lamps from controller, raw btn in;
//                   ped_req pulse, walk, stop, remain[6:0] seconds, sticky fault out (all registered).
module ped_signal #(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int WALK_SEC   = 20,
    parameter int BLINK_SEC  = 5,
    parameter int DEB_CYC    = 1_250_000,
    parameter int BLINK_HALF = 31_250_000,
    parameter int REQ_PULSE  = 4,
    parameter int FAULT_CYC  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    ped_signal_if.slave bus
);
    localparam int DIV_W = $clog2(CLK_FREQ + 1);
    localparam int DEB_W = $clog2(DEB_CYC + 1);
    localparam int BLK_W = $clog2(BLINK_HALF + 1);
    localparam int REQ_W = $clog2(REQ_PULSE + 1);
    localparam int FLT_W = $clog2(FAULT_CYC + 1);

    typedef enum logic [1:0] {S_STOP, S_WALK, S_BLINK, S_FAULT} state_t;

    state_t             state, state_n;
    logic [2:0]         car_m, car_s;
    logic               btn_m, btn_s, btn_deb, btn_deb_q;
    logic               red, red_q, red_rise, press, legal, fault_hit, tick, blink_flip, pulse_done;
    logic               pending, ped_req, walk, stop, fault, walk_n, stop_n;
    logic [6:0]         remain, remain_n, rem_dec;
    logic [DIV_W-1:0]   div_cnt;
    logic [DEB_W-1:0]   deb_cnt;
    logic [BLK_W-1:0]   blink_cnt;
    logic [REQ_W-1:0]   req_cnt;
    logic [FLT_W-1:0]   ill_cnt;

    // car_s bit order: {red, yellow, green}
    assign red        = car_s[2];
    assign red_rise   = red & ~red_q;
    assign press      = btn_deb & ~btn_deb_q;
    assign legal      = car_s inside {3'b001, 3'b010, 3'b100};
    assign fault_hit  = !legal && ill_cnt == FLT_W'(FAULT_CYC - 1);
    assign tick       = div_cnt == DIV_W'(CLK_FREQ - 1);
    assign blink_flip = blink_cnt == BLK_W'(BLINK_HALF - 1);
    assign pulse_done = ped_req && red && req_cnt == REQ_W'(REQ_PULSE - 1);
    assign rem_dec    = (tick && remain != '0) ? remain - 7'd1 : remain;

    assign bus.ped_req = ped_req;
    assign bus.walk    = walk;
    assign bus.stop    = stop;
    assign bus.remain  = remain;
    assign bus.fault   = fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_m <= '0;
            car_s <= '0;
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            red_q <= 1'b0;
        end else begin
            car_m <= {bus.car_red, bus.car_yellow, bus.car_green};
            car_s <= car_m;
            btn_m <= bus.btn;
            btn_s <= btn_m;
            red_q <= car_s[2];
        end
    end

    // Counter runs only while the synced button disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt   <= '0;
            btn_deb   <= 1'b0;
            btn_deb_q <= 1'b0;
        end else begin
            btn_deb_q <= btn_deb;
            deb_cnt   <= (btn_s == btn_deb || deb_cnt == DEB_W'(DEB_CYC - 1)) ? '0 : deb_cnt + 1'b1;
            btn_deb   <= (btn_s != btn_deb && deb_cnt == DEB_W'(DEB_CYC - 1)) ? btn_s : btn_deb;
        end
    end

    // A pulse cut short by red falling leaves pending set so it retries on the next red.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            ped_req <= 1'b0;
            req_cnt <= '0;
        end else if (state_n == S_FAULT) begin
            pending <= 1'b0;
            ped_req <= 1'b0;
            req_cnt <= '0;
        end else if (ped_req) begin
            ped_req <= red && !pulse_done;
            req_cnt <= (red && !pulse_done) ? req_cnt + 1'b1 : '0;
            pending <= !pulse_done;
        end else begin
            ped_req <= pending && red;
            req_cnt <= '0;
            pending <= pending || (press && state == S_STOP && state_n == S_STOP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            blink_cnt <= '0;
            ill_cnt   <= '0;
        end else begin
            div_cnt   <= (tick || (state_n == S_WALK && state != S_WALK)) ? '0 : div_cnt + 1'b1;
            blink_cnt <= (blink_flip || (state_n == S_BLINK && state != S_BLINK)) ? '0 : blink_cnt + 1'b1;
            ill_cnt   <= legal ? '0 : fault_hit ? ill_cnt : ill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_STOP;
            walk   <= 1'b0;
            stop   <= 1'b1;
            remain <= '0;
            fault  <= 1'b0;
        end else begin
            state  <= state_n;
            walk   <= walk_n;
            stop   <= stop_n;
            remain <= remain_n;
            fault  <= state_n == S_FAULT;
        end
    end

    // A pending request defers the walk until its pulse has been delivered.
    always_comb begin
        state_n  = state;
        walk_n   = 1'b0;
        stop_n   = 1'b1;
        remain_n = '0;
        case (state)
            S_STOP:  state_n = ((red_rise && !pending) || pulse_done) ? S_WALK : S_STOP;
            S_WALK:  state_n = !red ? S_STOP : (rem_dec <= 7'(BLINK_SEC)) ? S_BLINK : S_WALK;
            S_BLINK: state_n = (!red || rem_dec == '0) ? S_STOP : S_BLINK;
            default: state_n = S_FAULT;
        endcase
        if (fault_hit)
            state_n = S_FAULT;
        case (state_n)
            S_WALK: begin
                walk_n   = 1'b1;
                stop_n   = 1'b0;
                remain_n = (state == S_WALK) ? rem_dec : 7'(WALK_SEC);
            end
            S_BLINK: begin
                stop_n   = 1'b0;
                walk_n   = (state != S_BLINK) ? 1'b1 : walk ^ blink_flip;
                remain_n = rem_dec;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ped_signal.sv
// tb_ped_signal: directed scenarios with randomized timing, checked against a time-based walk model
module tb_ped_signal;
    localparam int CLK   = 100;
    localparam int WALK  = 6;
    localparam int BLINK = 2;
    localparam int HALF  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    ped_signal_if bus();

    ped_signal #(
        .CLK_FREQ(CLK), .WALK_SEC(WALK), .BLINK_SEC(BLINK), .DEB_CYC(5),
        .BLINK_HALF(HALF), .REQ_PULSE(4), .FAULT_CYC(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected lamps e cycles after entering walk with red held: one second per CLK cycles,
    // blinking once BLINK seconds remain, 2*HALF-cycle blink period starting lit.
    function automatic void model(input int e, output logic w, output logic s, output logic [6:0] r);
        int d;
        d = e / CLK;
        r = (d >= WALK) ? 7'd0 : 7'(WALK - d);
        s = (r == 7'd0);
        w = (r == 7'd0) ? 1'b0 : (r > 7'(BLINK)) ? 1'b1 : (((e - (WALK - BLINK) * CLK) / HALF) % 2 == 0);
    endfunction

    task automatic check_model(input string tag, input int e);
        logic w, s;
        logic [6:0] r;
        model(e, w, s, r);
        chk({tag, "_walk"}, bus.walk, w);
        chk({tag, "_stop"}, bus.stop, s);
        chk({tag, "_remain"}, bus.remain, r);
    endtask

    // Waits for a request pulse, measures it, and checks the walk that follows.
    task automatic req_pulse(input string tag);
        int n = 0;
        int hi = 0;
        while (bus.ped_req !== 1'b1 && n < 60) begin
            step(1);
            n++;
        end
        chk({tag, "_req_seen"}, bus.ped_req, 1);
        while (bus.ped_req === 1'b1 && hi < 20) begin
            step(1);
            hi++;
        end
        chk({tag, "_req_len"}, hi, 4);
        chk({tag, "_walk"}, bus.walk, 1);
        chk({tag, "_stop"}, bus.stop, 0);
        chk({tag, "_remain"}, bus.remain, WALK);
    endtask

    initial begin
        int d;
        bus.car_red = 1'b0;
        bus.car_green = 1'b1;
        bus.car_yellow = 1'b0;
        bus.btn = 1'b0;
        step(3);
        chk("rst_walk", bus.walk, 0);
        chk("rst_stop", bus.stop, 1);
        chk("rst_req", bus.ped_req, 0);
        chk("rst_remain", bus.remain, 0);
        chk("rst_fault", bus.fault, 0);
        rst_n = 1'b1;
        step(5);

        // Full walk cycle on a plain red rise.
        bus.car_green = 1'b0;
        bus.car_red = 1'b1;
        for (int s = 1; s <= 700; s++) begin
            step(1);
            if (s < 3) begin
                chk("s2_pre_walk", bus.walk, 0);
                chk("s2_pre_stop", bus.stop, 1);
            end else
                check_model("s2", s - 3);
            chk("s2_req", bus.ped_req, 0);
        end

        // Press after walk expired with red still on.
        bus.btn = 1'b1;
        req_pulse("s6");
        bus.btn = 1'b0;

        // Red drops while the countdown shows 4.
        d = $urandom_range(200, 299);
        step(d);
        check_model("s4_pre", d);
        bus.car_red = 1'b0;
        bus.car_yellow = 1'b1;
        step(2);
        chk("s4_sync_stop", bus.stop, 0);
        step(1);
        chk("s4_stop", bus.stop, 1);
        chk("s4_walk", bus.walk, 0);
        chk("s4_remain", bus.remain, 0);
        bus.car_yellow = 1'b0;
        bus.car_green = 1'b1;
        step(5);

        // Bouncy then held button during green.
        for (int g = 0; g < 3; g++) begin
            bus.btn = 1'b1;
            step(2);
            bus.btn = 1'b0;
            step($urandom_range(1, 3));
        end
        bus.btn = 1'b1;
        for (int s = 0; s < 30; s++) begin
            step(1);
            chk("s3_green_req", bus.ped_req, 0);
        end
        bus.car_green = 1'b0;
        bus.car_red = 1'b1;
        req_pulse("s3");
        bus.btn = 1'b0;

        // Asynchronous reset in the blinking phase.
        d = $urandom_range(401, 595);
        step(d);
        check_model("s1_pre", d);
        #2 rst_n = 1'b0;
        #1;
        chk("s1_walk", bus.walk, 0);
        chk("s1_stop", bus.stop, 1);
        chk("s1_remain", bus.remain, 0);
        chk("s1_fault", bus.fault, 0);
        bus.car_red = 1'b0;
        bus.car_green = 1'b1;
        step(1);
        chk("s1_hold_stop", bus.stop, 1);
        rst_n = 1'b1;
        step(5);

        // Illegal lamps: seven cycles tolerated, eight latch the fault.
        bus.car_red = 1'b1;
        step(7);
        bus.car_green = 1'b0;
        step(10);
        chk("s5_short_fault", bus.fault, 0);
        bus.car_green = 1'b1;
        step(8);
        bus.car_green = 1'b0;
        step(1);
        chk("s5_edge_fault", bus.fault, 0);
        step(1);
        chk("s5_fault", bus.fault, 1);
        chk("s5_stop", bus.stop, 1);
        chk("s5_walk", bus.walk, 0);
        chk("s5_remain", bus.remain, 0);
        bus.btn = 1'b1;
        for (int s = 0; s < 30; s++) begin
            step(1);
            chk("s5_hold_fault", bus.fault, 1);
            chk("s5_hold_req", bus.ped_req, 0);
        end
        rst_n = 1'b0;
        #1;
        chk("s5_reset_fault", bus.fault, 0);
        chk("s5_reset_stop", bus.stop, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ped_signal.md
Name: ped_signal

Overview:
- Pedestrian-side companion to the vehicle traffic controller.
- Consumes the controller's lamp outputs (RED/GREEN/YELLOW) and drives the pedestrian WALK/STOP lamps, with a walk countdown and a blinking warning phase.
- Debounces the raw pedestrian button and generates a request pulse back to the controller's PED_SW input, timed so that the controller's rising-edge detector sees it.

Parameters:
CLK_FREQ, 125_000_000, clock frequency in Hz; sets the 1 s tick.
WALK_SEC, 20, walk duration in seconds (1..127).
BLINK_SEC, 5, final seconds of walk shown as blinking (< WALK_SEC).
DEB_CYC, 1_250_000, cycles the button must be stable to be accepted (10 ms).
BLINK_HALF, 31_250_000, WALK half-period in cycles during blinking (2 Hz).
REQ_PULSE, 4, PED_REQ high time in cycles.
FAULT_CYC, 1000, consecutive illegal-lamp cycles before fault.

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
CAR_RED  in  1  vehicle red lamp from controller
CAR_GREEN  in  1  vehicle green lamp
CAR_YELLOW  in  1  vehicle yellow lamp
BTN  in  1  raw pedestrian button, asynchronous, bouncy
PED_REQ  out  1  request pulse to controller PED_SW
WALK  out  1  pedestrian walk lamp
STOP  out  1  pedestrian don't-walk lamp
REMAIN  out  7  walk seconds remaining, unsigned
FAULT  out  1  sticky lamp-fault flag

Behaviour:
- Reset (async on RST_N low): WALK=0, STOP=1, PED_REQ=0, REMAIN=0, FAULT=0, state sSTOP, pending=0; all counters and sync flops cleared.
- Sync and debounce:
  - CAR_* and BTN pass through 2-flop synchronizers.
  - The debounced button updates only after DEB_CYC identical consecutive synced samples.
  - A press is the 0->1 edge of the debounced button.
- Request path:
  - A press in sSTOP sets pending. Presses in sWALK, sBLINK or sFAULT are ignored.
  - When pending=1 and synced CAR_RED=1, PED_REQ goes high for exactly REQ_PULSE cycles, then pending clears.
  - A press while the pulse is active is absorbed and does not extend it. PED_REQ is never asserted while CAR_RED=0.
- 1 s tick: free-running divider counting 0..CLK_FREQ-1. It restarts at 0 on every entry to sWALK, so the first decrement occurs CLK_FREQ cycles after entry.
- Illegal lamp combination: any cycle where the number of synced CAR_* bits high is not exactly one.
- States:
  - sSTOP: STOP=1, WALK=0, REMAIN=0.
    - Rising edge of synced CAR_RED -> sWALK.
    - PED_REQ pulse completing with CAR_RED=1 -> sWALK.
    - On entry to sWALK, REMAIN loads WALK_SEC.
  - sWALK: WALK=1, STOP=0.
    - REMAIN decrements on each tick.
    - REMAIN <= BLINK_SEC -> sBLINK.
    - CAR_RED=0 -> sSTOP immediately; this takes priority.
  - sBLINK: STOP=0. WALK toggles every BLINK_HALF cycles, starting at 1 on entry.
    - REMAIN keeps decrementing.
    - REMAIN reaches 0 -> sSTOP.
    - CAR_RED=0 -> sSTOP immediately.
  - sFAULT: entered from any state after FAULT_CYC consecutive illegal cycles.
    - STOP=1, WALK=0, FAULT=1, REMAIN=0, PED_REQ=0.
    - Exit only by reset. A single legal cycle resets the illegal counter.
- Arithmetic: REMAIN saturates at 0 and never wraps. The divider and debounce counters are sized with $clog2 of their limits.
- Latency: a CAR_RED edge reaches the WALK output 3 cycles later (2 sync + state register). All outputs are registered.
- Simultaneous events: a CAR_RED fall in the same cycle as a tick gives sSTOP, with REMAIN=0 the next cycle. Fault detection has priority over every other transition.

Test Plan:
All scenarios use CLK_FREQ=100, DEB_CYC=5, BLINK_HALF=10, REQ_PULSE=4, FAULT_CYC=8, WALK_SEC=6, BLINK_SEC=2.
1. Reset asserted mid-sBLINK -> next cycle WALK=0, STOP=1, REMAIN=0, FAULT=0.
2. CAR_GREEN=1 then CAR_RED=1 held 700 cycles -> WALK=1 at +3 cycles with REMAIN=6. REMAIN=2 at +403, blink period 20 cycles. STOP=1 when REMAIN=0 at +603.
3. BTN bounces 3 times (2-cycle glitches) then held during GREEN -> no PED_REQ. When CAR_RED rises, PED_REQ is high exactly 4 cycles, then sWALK.
4. CAR_RED drops to YELLOW while REMAIN=4 -> STOP=1, WALK=0, REMAIN=0 within 3 cycles.
5. CAR_RED and CAR_GREEN both high for 7 cycles, then legal -> no fault. Both high for 8 cycles -> FAULT=1, STOP=1, held until RST_N low.
6. Walk expired, CAR_RED still high, BTN pressed -> 4-cycle PED_REQ pulse, then re-entry to sWALK with REMAIN=6.
